// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default line parameters
// used by both the transmit and receive sides.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Zero-extended payloads leave the XOR unchanged, so narrower frames can use this too.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Baud counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 while enabled
// and flags the last cycle of each bit period with bit_tick.
module uart_tx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == CNT_MAX);
    assign bit_tick = en && w_wrap;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: accepts one byte per valid/ready handshake and serialises it
// as start bit, data LSB-first, optional parity and one or two stop bits.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_e            r_state, w_state_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_d;
    logic                 r_parity, w_parity_d;
    logic                 r_tx, w_tx_d;
    logic                 r_done, w_done_d;
    logic                 w_bit_tick;
    logic                 w_idle;

    assign w_idle = (r_state == IDLE);

    uart_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (!w_idle),
        .clr     (w_idle),
        .bit_tick(w_bit_tick)
    );

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_parity_d  = r_parity;
        w_done_d    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_shift_d   = tx_data;
                    w_parity_d  = calc_parity(8'(tx_data), PARITY_ODD != 0);
                    w_bit_cnt_d = '0;
                    w_state_d   = START;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_bit_cnt_d = '0;
                    w_state_d   = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            w_state_d = PARITY;
                        end else begin
                            w_state_d = STOP;
                        end
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
                        w_shift_d   = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_bit_cnt_d = '0;
                    w_state_d   = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_bit_cnt_d = '0;
                        w_done_d    = 1'b1;
                        w_state_d   = IDLE;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Line level follows the next state so it changes on the same edge as the FSM.
        case (w_state_d)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_shift_d[0];
            PARITY:  w_tx_d = r_parity;
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_parity  <= w_parity_d;
            r_tx      <= w_tx_d;
            r_done    <= w_done_d;
        end
    end

    assign tx_ready = w_idle;
    assign tx_busy  = !w_idle;
    assign tx       = r_tx;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at CLKS_PER_BIT=4: 8N1, even parity and odd parity
// instances share stimulus; outputs of the instance under test are chosen by sel.
module tb_uart_tx_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] w_ready, w_tx, w_busy, w_done;
    int         sel = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_unit #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(w_ready[0]), .tx(w_tx[0]), .tx_busy(w_busy[0]), .tx_done(w_done[0])
    );
    uart_tx_unit #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(w_ready[1]), .tx(w_tx[1]), .tx_busy(w_busy[1]), .tx_done(w_done[1])
    );
    uart_tx_unit #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(w_ready[2]), .tx(w_tx[2]), .tx_busy(w_busy[2]), .tx_done(w_done[2])
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (w_ready !== 3'b111 && t < 200) begin
            step(1);
            t++;
        end
        n_vec++;
        if (w_ready !== 3'b111) begin
            n_err++;
            $display("FAIL wait_idle: ready=%b want 111", w_ready);
        end
    endtask

    // Leaves the caller in the first cycle after the handshake edge.
    task automatic send(input logic [7:0] d, input bit hold);
        tx_data  = d;
        tx_valid = 1'b1;
        step(1);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Starts in cycle H+1; samples mid-bit (H+2, H+6, ...) and stops on tx_done.
    task automatic capture(input int n, input int inject, output logic [11:0] bits,
                           output int done_at, output bit ready_bad);
        int idx = 0;
        bits = '0;
        done_at = -1;
        ready_bad = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c >= 2 && ((c - 2) % 4) == 0 && idx < n) begin
                bits[idx] = w_tx[sel];
                idx++;
            end
            if (w_done[sel]) begin
                done_at = c;
                break;
            end
            if (w_ready[sel] || !w_busy[sel]) ready_bad = 1'b1;
            if (inject != 0 && c == inject) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (inject != 0 && c == inject + 1) tx_valid = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        n_vec++;
        if (w_tx !== 3'b111) begin
            n_err++; $display("FAIL reset_tx: got %b want 111", w_tx);
        end
        n_vec++;
        if (w_ready !== 3'b111) begin
            n_err++; $display("FAIL reset_ready: got %b want 111", w_ready);
        end
        n_vec++;
        if (w_busy !== 3'b000) begin
            n_err++; $display("FAIL reset_busy: got %b want 000", w_busy);
        end
        n_vec++;
        if (w_done !== 3'b000) begin
            n_err++; $display("FAIL reset_done: got %b want 000", w_done);
        end
    endtask

    task automatic test_frame();
        logic [11:0] bits;
        int          done_at;
        bit          rb;
        sel = 0;
        wait_idle();
        send(8'hA5, 1'b0);
        n_vec++;
        if (w_tx[0] !== 1'b0) begin
            n_err++; $display("FAIL frame_start_edge: tx=%b want 0", w_tx[0]);
        end
        capture(10, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b00_1101001010) begin
            n_err++; $display("FAIL frame_bits: got %b want 001101001010", bits);
        end
        n_vec++;
        if (done_at !== 41) begin
            n_err++; $display("FAIL frame_done_at: got %0d want 41", done_at);
        end
        n_vec++;
        if (rb !== 1'b0) begin
            n_err++; $display("FAIL frame_busy: ready/busy wrong mid-frame (%b) want 0", rb);
        end
        step(1);
        n_vec++;
        if (w_done[0] !== 1'b0) begin
            n_err++; $display("FAIL frame_done_width: done=%b want 0", w_done[0]);
        end
    endtask

    task automatic test_parity();
        logic [11:0] bits;
        int          done_at;
        bit          rb;
        // {stop, parity, data, start}
        sel = 1;
        wait_idle();
        send(8'h07, 1'b0);
        capture(11, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b0_11_00000111_0) begin
            n_err++; $display("FAIL parity_even_07: got %b want 011000001110", bits);
        end
        n_vec++;
        if (done_at !== 45) begin
            n_err++; $display("FAIL parity_done_at: got %0d want 45", done_at);
        end
        wait_idle();
        send(8'h00, 1'b0);
        capture(11, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b0_10_00000000_0) begin
            n_err++; $display("FAIL parity_even_00: got %b want 010000000000", bits);
        end
        sel = 2;
        wait_idle();
        send(8'h07, 1'b0);
        capture(11, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b0_10_00000111_0) begin
            n_err++; $display("FAIL parity_odd_07: got %b want 010000001110", bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits;
        int          done_at;
        bit          rb;
        sel = 0;
        wait_idle();
        send(8'h55, 1'b1);
        tx_data = 8'h0F;
        capture(10, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b00_1010101010) begin
            n_err++; $display("FAIL b2b_first_bits: got %b want 001010101010", bits);
        end
        n_vec++;
        if (done_at !== 41 || w_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first_done: done_at=%0d ready=%b want 41/1", done_at, w_ready[0]);
        end
        step(1);
        tx_valid = 1'b0;
        n_vec++;
        if (w_tx[0] !== 1'b0 || w_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_start: tx=%b ready=%b want 0/0", w_tx[0], w_ready[0]);
        end
        capture(10, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b00_1000011110) begin
            n_err++; $display("FAIL b2b_second_bits: got %b want 001000011110", bits);
        end
    endtask

    task automatic test_busy_ignore();
        logic [11:0] bits;
        int          done_at;
        bit          rb;
        bit          extra = 1'b0;
        sel = 0;
        wait_idle();
        send(8'h3C, 1'b0);
        capture(10, 10, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b00_1001111000) begin
            n_err++; $display("FAIL busy_bits: got %b want 001001111000", bits);
        end
        n_vec++;
        if (rb !== 1'b0) begin
            n_err++; $display("FAIL busy_ready: ready rose mid-frame (%b) want 0", rb);
        end
        n_vec++;
        if (done_at !== 41) begin
            n_err++; $display("FAIL busy_done_at: got %0d want 41", done_at);
        end
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (w_done[0] !== 1'b0 || w_tx[0] !== 1'b1) extra = 1'b1;
        end
        n_vec++;
        if (extra !== 1'b0) begin
            n_err++; $display("FAIL busy_extra_frame: activity after frame (%b) want 0", extra);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] bits;
        int          done_at;
        bit          rb;
        bit          quiet_bad = 1'b0;
        sel = 0;
        wait_idle();
        send(8'h81, 1'b0);
        step(17);
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        step(1);
        n_vec++;
        if (w_tx[0] !== 1'b1 || w_ready[0] !== 1'b1 || w_done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: tx=%b ready=%b done=%b want 1/1/0",
                     w_tx[0], w_ready[0], w_done[0]);
        end
        step(1);
        n_vec++;
        if (w_tx[0] !== 1'b1 || w_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_vs_valid: tx=%b ready=%b want 1/1", w_tx[0], w_ready[0]);
        end
        reset    = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(1);
            if (w_done[0] !== 1'b0 || w_tx[0] !== 1'b1) quiet_bad = 1'b1;
        end
        n_vec++;
        if (quiet_bad !== 1'b0) begin
            n_err++; $display("FAIL rst_quiet: line/done active after reset (%b) want 0", quiet_bad);
        end
        send(8'h81, 1'b0);
        capture(10, 0, bits, done_at, rb);
        n_vec++;
        if (bits !== 12'b00_1100000010 || done_at !== 41) begin
            n_err++;
            $display("FAIL rst_resend: bits=%b done_at=%0d want 001100000010/41", bits, done_at);
        end
    endtask

    task automatic test_loopback();
        logic [11:0] bits;
        logic [7:0]  b;
        int          done_at;
        bit          rb;
        sel = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            wait_idle();
            send(b, 1'b0);
            capture(10, 0, bits, done_at, rb);
            n_vec++;
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== b) begin
                n_err++;
                $display("FAIL loopback_%0d: frame=%b got byte %h want %h", i, bits, bits[8:1], b);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
